des_key_schedule: RTL and testbench
===================================

# des_key_schedule

Sequential DES key-schedule engine. It accepts a 64-bit key, applies Permuted Choice 1 and steps the 28-bit C/D halves through the 16 per-round rotations, one round per accepted handshake. Each round it presents the 56-bit rotated C‖D word that `key_pc2` consumes to form the round subkey. It supports encryption (left rotations, K1→K16) and decryption (right rotations, K16→K1) and sits directly upstream of `key_pc2` in the round datapath.

## Interface
- Parameters: none; the round count (16) and shift schedule are fixed by DES.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  load `key_in` and begin a schedule; accepted only when `busy`=0.
- `key_in`  in  64  DES key; `key_in[63]` = DES key bit 1 (conventional hex order); parity bits ignored.
- `decrypt`  in  1  sampled with `start`: 0 = encrypt order, 1 = decrypt order.
- `busy`  out  1  high from the cycle after accepted `start` until the final round is consumed.
- `cd_out`  out  56  current C‖D; `cd_out[0]` = C bit 1, `cd_out[27]` = C bit 28, `cd_out[28]` = D bit 1, `cd_out[55]` = D bit 28. Feeds `key_pc2.in`.
- `cd_valid`  out  1  `cd_out` holds the word for round `round`.
- `cd_ready`  in  1  consumer accepts the current word; the round advances on `cd_valid && cd_ready`.
- `round`  out  4  0-based round index of `cd_out` (0..15).
- `done`  out  1  one-cycle pulse after round 15 is accepted.

## Operation
- PC1: `cd[i] = key_in[64 - PC1[i]]`, with PC1 = 57 49 41 33 25 17 9 1 58 50 42 34 26 18 10 2 59 51 43 35 27 19 11 3 60 52 44 36 | 63 55 47 39 31 23 15 7 62 54 46 38 30 22 14 6 61 53 45 37 29 21 13 5 28 20 12 4.
- DES left rotate by 1 on a half h[27:0] in this bit order: `h' [i] = h[i+1]`, `h'[27] = h[0]`. Right rotate is the inverse. C and D always rotate independently by the same amount.
- Shift schedule S[1..16] = 1 1 2 2 2 2 2 2 1 2 2 2 2 2 2 1.
- Encrypt: round r (1-based) word = PC1 rotated left by S[1]+…+S[r]. Load value is PC1 rotated left by 1. Each accepted handshake rotates left by S[r+1].
- Decrypt: round 1 word = PC1 unrotated, which equals K16's C‖D. The step into round r≥2 rotates right by S[18-r], giving 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1.
- FSM states:
  - IDLE → ACTIVE on `start`. The PC1 result is loaded, `round`=0, `decrypt` is latched, `cd_valid`=1.
  - ACTIVE with handshake and `round`<15: rotate, `round`+1.
  - ACTIVE with handshake and `round`=15: go to IDLE, `cd_valid`=0, `busy`=0, `done`=1 for one cycle. `cd_out` holds its last value.
- Shift amounts come from a case on (`round`, latched direction). There is no separate shift counter; `round` never wraps past 15.
- `start` while `busy`=1 is ignored; the key and direction are unchanged.
- `start` in the same cycle as the final handshake is ignored, because `busy` is still 1. A new `start` is accepted in the cycle `done` is high.
- Changes to `key_in` or `decrypt` while ACTIVE have no effect.

## Timing
- Reset values (asynchronous on `rst_n`=0): `cd_out`=0, `cd_valid`=0, `busy`=0, `round`=0, `done`=0, state IDLE.
- Reset mid-schedule aborts immediately to the reset values. `done` is not pulsed.
- Latency: `start` at edge N → `cd_valid`=1 with the round-0 word after edge N.
- Throughput: one round per cycle with `cd_ready` held high, so 16 cycles of `cd_valid` and `done` in the 17th.
- `cd_ready`=0 stalls: `cd_out`, `round` and `cd_valid` are held stable indefinitely.
- All outputs are registered; there is no combinational path from `cd_ready` or `start` to any output.

## Test plan
- Encrypt, key 64'h133457799BBCDFF1, `cd_ready`=1 → `key_pc2(cd_out)` reads 48'h1B02EFFC7072 at round 0, 48'h79AED9DBC9E5 at round 1, 48'hCB3D8B0E17F5 at round 15. `done` pulses exactly 16 cycles after the first `cd_valid`.
- Decrypt, same key → round 0 gives 48'hCB3D8B0E17F5, round 14 gives 48'h79AED9DBC9E5, round 15 gives 48'h1B02EFFC7072.
- Stall: deassert `cd_ready` for 5 cycles at round 3 → `cd_out` and `round`=3 remain constant. The sequence resumes with the identical subkeys as the unstalled run.
- Start while busy: pulse `start` with key 64'hFFFFFFFFFFFFFFFF at round 7 → ignored, and the remaining subkeys match the original key. Back-to-back `start` during the `done` cycle is accepted.
- Reset mid-run: assert `rst_n`=0 at round 9 → all outputs are 0 within the reset cycle and no `done` is produced. A subsequent `start` yields the correct round 0 word.
- Key 64'h0 → `cd_out`=0 for all 16 rounds. Key 64'hFEFEFEFEFEFEFEFE (parity-only differences from all-ones) → `cd_out` is all-ones every round.

Source files
------------

// File: rtl/des_key_schedule.sv
// DES key-schedule engine: PC1 load, then one C/D rotation per accepted round handshake.
// Produces the rotated C||D word that key_pc2 turns into each round subkey.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        busy,
    output logic [55:0] cd_out,
    output logic        cd_valid,
    input  logic        cd_ready,
    output logic [3:0]  round,
    output logic        done
);

    localparam int unsigned KEY_W      = 64;
    localparam int unsigned CD_W       = 56;
    localparam int unsigned HALF_W     = 28;
    localparam int unsigned ROUND_W    = 4;
    localparam int unsigned LAST_ROUND = 15;

    // PC1[i] is the 1-based DES key bit that lands in cd bit i (C bits 0..27, D bits 28..55)
    localparam int unsigned PC1 [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CD_W-1:0]     cd_q, cd_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic                dec_q, dec_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [CD_W-1:0]     pc1_c;
    logic                shift_two_c;

    for (genvar i = 0; i < CD_W; i++) begin : g_pc1
        assign pc1_c[i] = key_in[KEY_W - PC1[i]];
    end

    // Bit 0 of a half is DES bit 1, so a DES left rotate moves bits toward index 0.
    function automatic logic [HALF_W-1:0] rot_l(input logic [HALF_W-1:0] h, input logic two);
        return two ? {h[1:0], h[HALF_W-1:2]} : {h[0], h[HALF_W-1:1]};
    endfunction

    function automatic logic [HALF_W-1:0] rot_r(input logic [HALF_W-1:0] h, input logic two);
        return two ? {h[HALF_W-3:0], h[HALF_W-1:HALF_W-2]} : {h[HALF_W-2:0], h[HALF_W-1]};
    endfunction

    // Step out of the current round; the decrypt schedule is the encrypt one reversed,
    // which puts the single-bit steps at the same round indices.
    always_comb begin
        shift_two_c = 1'b1;
        case ({dec_q, round_q})
            {1'b0, 4'd0}, {1'b0, 4'd7}, {1'b0, 4'd14}: shift_two_c = 1'b0;
            {1'b1, 4'd0}, {1'b1, 4'd7}, {1'b1, 4'd14}: shift_two_c = 1'b0;
            default:                                   shift_two_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACTIVE;
                    dec_d   = decrypt;
                    round_d = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    // Encrypt presents K1 (one left step); decrypt presents K16 (PC1 as-is).
                    cd_d    = decrypt ? pc1_c
                                      : {rot_l(pc1_c[CD_W-1:HALF_W], 1'b0),
                                         rot_l(pc1_c[HALF_W-1:0], 1'b0)};
                end
            end
            S_ACTIVE: begin
                if (cd_ready) begin
                    if (round_q == ROUND_W'(LAST_ROUND)) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        cd_d    = dec_q ? {rot_r(cd_q[CD_W-1:HALF_W], shift_two_c),
                                           rot_r(cd_q[HALF_W-1:0], shift_two_c)}
                                        : {rot_l(cd_q[CD_W-1:HALF_W], shift_two_c),
                                           rot_l(cd_q[HALF_W-1:0], shift_two_c)};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cd_out   = cd_q;
    assign round    = round_q;
    assign cd_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: subkeys via a reference PC2 against the
// classic 133457799BBCDFF1 schedule, plus stall, busy-start, reset and corner keys.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        busy;
    logic [55:0] cd_out;
    logic        cd_valid;
    logic        cd_ready;
    logic [3:0]  round;
    logic        done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
    localparam logic [55:0] ONES = 56'hFFFFFFFFFFFFFF;

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // K1..K16 for KEY (index 0 = K1)
    localparam logic [47:0] KS [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_schedule dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .decrypt  (decrypt),
        .busy     (busy),
        .cd_out   (cd_out),
        .cd_valid (cd_valid),
        .cd_ready (cd_ready),
        .round    (round),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] k;
        k = '0;
        for (int j = 0; j < 48; j++) k[47-j] = cd[PC2_T[j]-1];
        return k;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_round(input string tag, input int r, input logic [47:0] k);
        check($sformatf("%s_valid_r%0d", tag, r), 64'(cd_valid), 64'd1);
        check($sformatf("%s_busy_r%0d", tag, r), 64'(busy), 64'd1);
        check($sformatf("%s_round_r%0d", tag, r), 64'(round), 64'(r));
        check($sformatf("%s_done_r%0d", tag, r), 64'(done), 64'd0);
        check($sformatf("%s_subkey_r%0d", tag, r), 64'(pc2(cd_out)), 64'(k));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        decrypt  = 1'b0;
        cd_ready = 1'b0;
        tick();
        tick();
        check("rst_cd_out", 64'(cd_out), 64'd0);
        check("rst_valid", 64'(cd_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        // Encrypt, ready held high: 16 rounds then done
        key_in   = KEY;
        decrypt  = 1'b0;
        cd_ready = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check_round("enc", r, KS[r]);
            tick();
        end
        check("enc_done", 64'(done), 64'd1);
        check("enc_busy_end", 64'(busy), 64'd0);
        check("enc_valid_end", 64'(cd_valid), 64'd0);
        check("enc_hold_last", 64'(pc2(cd_out)), 64'(KS[15]));

        // Back-to-back decrypt start during the done cycle
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check_round("dec", r, KS[15-r]);
            tick();
        end
        check("dec_done", 64'(done), 64'd1);
        tick();
        check("dec_done_pulse", 64'(done), 64'd0);
        check("dec_idle_busy", 64'(busy), 64'd0);

        // Encrypt with a 5-cycle stall at round 3 and an ignored start at round 7
        decrypt = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check_round("stl", r, KS[r]);
            if (r == 3) begin
                cd_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check($sformatf("stall_round_c%0d", s), 64'(round), 64'd3);
                    check($sformatf("stall_valid_c%0d", s), 64'(cd_valid), 64'd1);
                    check($sformatf("stall_subkey_c%0d", s), 64'(pc2(cd_out)), 64'(KS[3]));
                end
                cd_ready = 1'b1;
            end
            if (r == 7) begin
                key_in  = 64'hFFFFFFFFFFFFFFFF;
                decrypt = 1'b1;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("stl_done", 64'(done), 64'd1);
        tick();

        // Reset at round 9 aborts the schedule without a done pulse
        key_in  = KEY;
        decrypt = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("pre_rst_round", 64'(round), 64'd9);
        rst_n = 1'b0;
        #2;
        check("mid_rst_cd_out", 64'(cd_out), 64'd0);
        check("mid_rst_valid", 64'(cd_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_round", 64'(round), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("post_rst_done_c%0d", c), 64'(done), 64'd0);
            check($sformatf("post_rst_valid_c%0d", c), 64'(cd_valid), 64'd0);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check_round("restart", 0, KS[0]);
        repeat (16) tick();
        check("restart_done", 64'(done), 64'd1);

        // All-zero key: every round word is zero
        key_in = '0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check($sformatf("zero_valid_r%0d", r), 64'(cd_valid), 64'd1);
            check($sformatf("zero_cd_r%0d", r), 64'(cd_out), 64'd0);
            tick();
        end
        check("zero_done", 64'(done), 64'd1);

        // Parity bits are dropped by PC1, so FEFE.. behaves like all ones
        key_in  = 64'hFEFEFEFEFEFEFEFE;
        decrypt = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            check($sformatf("par_round_r%0d", r), 64'(round), 64'(r));
            check($sformatf("par_cd_r%0d", r), 64'(cd_out), 64'(ONES));
            tick();
        end
        check("par_done", 64'(done), 64'd1);
        tick();
        check("par_idle_done", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
